// File: rtl/dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dram_arbiter
// Brief    : Round-robin two-master front end for the single-port data RAM,
//            with a bounded burst lock for port 1 and per-port read return.
// Revision : 1.0 - initial release
// ============================================================================
module dram_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int LOCK_MAX   = 64
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    m0_req,
  input  logic                    m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_be,
  output logic                    m0_gnt,
  output logic                    m0_rvalid,
  output logic [DATA_WIDTH-1:0]   m0_rdata,

  input  logic                    m1_req,
  input  logic                    m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_be,
  input  logic                    m1_lock,
  output logic                    m1_gnt,
  output logic                    m1_rvalid,
  output logic [DATA_WIDTH-1:0]   m1_rdata,

  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wr_data,
  output logic                    ram_wr_en,
  output logic [DATA_WIDTH/8-1:0] ram_wr_byte_en,
  input  logic [DATA_WIDTH-1:0]   ram_rd_data
);

  localparam int C_BE_WIDTH  = DATA_WIDTH / 8;
  localparam int C_CNT_WIDTH = $clog2(LOCK_MAX + 1);
  localparam logic [C_CNT_WIDTH-1:0] C_LOCK_MAX = C_CNT_WIDTH'(LOCK_MAX);
  localparam logic [C_CNT_WIDTH-1:0] C_CNT_ONE  = C_CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_BLOCKED = 2'd2
  } lock_state_t;

  lock_state_t             r_state;
  lock_state_t             w_state_nxt;
  logic [C_CNT_WIDTH-1:0]  r_lock_cnt;
  logic [C_CNT_WIDTH-1:0]  w_lock_cnt_nxt;
  logic [C_CNT_WIDTH-1:0]  w_lock_cnt_inc;
  logic                    r_last_gnt;
  logic                    w_last_gnt_nxt;
  logic                    r_m0_rvalid;
  logic                    r_m1_rvalid;
  logic                    w_m0_gnt;
  logic                    w_m1_gnt;
  logic                    w_lock_excl;

  // Grants are suppressed while reset is held so no access slips through.
  always_comb begin
    w_m0_gnt    = 1'b0;
    w_m1_gnt    = 1'b0;
    w_lock_excl = (r_state == ST_LOCKED) && m1_lock;
    if (rst) begin
      if (w_lock_excl) begin
        w_m1_gnt = m1_req;
      end else if (m0_req && m1_req) begin
        w_m0_gnt = r_last_gnt;
        w_m1_gnt = ~r_last_gnt;
      end else begin
        w_m0_gnt = m0_req;
        w_m1_gnt = m1_req;
      end
    end
  end

  assign w_lock_cnt_inc = (r_lock_cnt == '1) ? r_lock_cnt : r_lock_cnt + C_CNT_ONE;

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    w_last_gnt_nxt = r_last_gnt;
    if (w_m0_gnt || w_m1_gnt) begin
      w_last_gnt_nxt = w_m1_gnt;
    end
    case (r_state)
      ST_IDLE: begin
        if (w_m1_gnt && m1_lock) begin
          w_state_nxt    = ST_LOCKED;
          w_lock_cnt_nxt = C_CNT_ONE;
        end
      end
      ST_LOCKED: begin
        if (!m1_lock) begin
          w_state_nxt    = ST_IDLE;
          w_lock_cnt_nxt = '0;
        end else begin
          w_lock_cnt_nxt = w_lock_cnt_inc;
          // Forced release hands the next conflict to port 0.
          if (w_lock_cnt_inc >= C_LOCK_MAX) begin
            w_state_nxt    = ST_BLOCKED;
            w_last_gnt_nxt = 1'b1;
          end
        end
      end
      ST_BLOCKED: begin
        if (!m1_lock) begin
          w_state_nxt    = ST_IDLE;
          w_lock_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_lock_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_lock_cnt  <= '0;
      r_last_gnt  <= 1'b1;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lock_cnt  <= w_lock_cnt_nxt;
      r_last_gnt  <= w_last_gnt_nxt;
      r_m0_rvalid <= w_m0_gnt & ~m0_we;
      r_m1_rvalid <= w_m1_gnt & ~m1_we;
    end
  end

  assign m0_gnt    = w_m0_gnt;
  assign m1_gnt    = w_m1_gnt;
  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  // The RAM has no output register, so its data lines up with the rvalid cycle.
  assign m0_rdata  = r_m0_rvalid ? ram_rd_data : '0;
  assign m1_rdata  = r_m1_rvalid ? ram_rd_data : '0;

  assign ram_addr       = w_m1_gnt ? m1_addr  : m0_addr;
  assign ram_wr_data    = w_m1_gnt ? m1_wdata : m0_wdata;
  assign ram_wr_en      = (w_m0_gnt & m0_we) | (w_m1_gnt & m1_we);
  assign ram_wr_byte_en = w_m1_gnt ? m1_be :
                          (w_m0_gnt ? m0_be : {C_BE_WIDTH{1'b0}});

endmodule
`default_nettype wire

// File: tb/tb_dram_arbiter.sv
`default_nettype none
// Bench for dram_arbiter: behavioural RAM, abstract arbitration model checked
// every negedge, plus directed scenarios with literal expectations.
module tb_dram_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int LM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic [BW-1:0] m0_be = '0;
  logic          m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic [BW-1:0] m1_be = '0;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data;
  logic          ram_wr_en;
  logic [BW-1:0] ram_wr_byte_en;
  logic [DW-1:0] ram_rd_data = '0;

  int vectors = 0;
  int miscompares = 0;

  dram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
    .ram_wr_byte_en(ram_wr_byte_en), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return {16'hC0DE, 2'b00, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural single-port RAM, 1-cycle read latency, write-first output.
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  bit            ram_written [0:(1<<AW)-1];
  always @(posedge clk) begin : p_ram
    logic [DW-1:0] cur;
    cur = ram_written[ram_addr] ? ram_mem[ram_addr] : init_word(ram_addr);
    if (ram_wr_en) begin
      for (int b = 0; b < BW; b++)
        if (ram_wr_byte_en[b]) cur[8*b +: 8] = ram_wr_data[8*b +: 8];
      ram_mem[ram_addr]     <= cur;
      ram_written[ram_addr] <= 1'b1;
    end
    ram_rd_data <= cur;
  end

  // Reference model: who owns the RAM this cycle, and what each master sees next.
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  bit            shadow_written [0:(1<<AW)-1];
  int            owner_mode = 0;   // 0 free, 1 port-1 exclusive, 2 exclusive exhausted
  int            held_cycles = 0;
  int            recent_port = 1;
  logic          pend0 = 1'b0, pend1 = 1'b0;
  logic [DW-1:0] pdat0 = '0, pdat1 = '0;

  function automatic logic [DW-1:0] shadow_rd(input logic [AW-1:0] a);
    return shadow_written[a] ? shadow[a] : init_word(a);
  endfunction

  always @(negedge clk) begin : p_model
    logic e0, e1;
    logic [DW-1:0] w;
    logic [AW-1:0] a;
    e0 = 1'b0;
    e1 = 1'b0;
    if (rst) begin
      if (owner_mode == 1 && m1_lock) e1 = m1_req;
      else if (m0_req && m1_req) begin
        e0 = (recent_port == 1);
        e1 = (recent_port == 0);
      end else begin
        e0 = m0_req;
        e1 = m1_req;
      end
    end
    check("m0_gnt", 32'(m0_gnt), 32'(e0));
    check("m1_gnt", 32'(m1_gnt), 32'(e1));
    check("ram_addr", 32'(ram_addr), 32'(e1 ? m1_addr : m0_addr));
    check("ram_wr_en", 32'(ram_wr_en), 32'((e0 && m0_we) || (e1 && m1_we)));
    check("ram_wr_byte_en", 32'(ram_wr_byte_en), 32'(e0 ? m0_be : (e1 ? m1_be : 4'b0)));
    if (e0 || e1) check("ram_wr_data", ram_wr_data, e1 ? m1_wdata : m0_wdata);
    check("m0_rvalid", 32'(m0_rvalid), 32'(rst && pend0));
    check("m1_rvalid", 32'(m1_rvalid), 32'(rst && pend1));
    check("m0_rdata", m0_rdata, (rst && pend0) ? pdat0 : 32'h0);
    check("m1_rdata", m1_rdata, (rst && pend1) ? pdat1 : 32'h0);

    if (!rst) begin
      owner_mode  = 0;
      held_cycles = 0;
      recent_port = 1;
      pend0 = 1'b0;
      pend1 = 1'b0;
    end else begin
      pend0 = e0 && !m0_we;
      pend1 = e1 && !m1_we;
      pdat0 = shadow_rd(m0_addr);
      pdat1 = shadow_rd(m1_addr);
      if ((e0 && m0_we) || (e1 && m1_we)) begin
        a = e1 ? m1_addr : m0_addr;
        w = shadow_rd(a);
        for (int b = 0; b < BW; b++)
          if ((e1 ? m1_be[b] : m0_be[b])) w[8*b +: 8] = (e1 ? m1_wdata[8*b +: 8] : m0_wdata[8*b +: 8]);
        shadow[a] = w;
        shadow_written[a] = 1'b1;
      end
      if (e0) recent_port = 0;
      if (e1) recent_port = 1;
      if (owner_mode == 0) begin
        if (e1 && m1_lock) begin
          owner_mode  = 1;
          held_cycles = 1;
        end
      end else if (!m1_lock) begin
        owner_mode  = 0;
        held_cycles = 0;
      end else if (owner_mode == 1) begin
        held_cycles = held_cycles + 1;
        if (held_cycles >= LM) begin
          owner_mode  = 2;
          recent_port = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : p_stim
    int c0, c1, dual;
    logic exp1;
    repeat (3) tick();

    // Simultaneous reads right after reset: port 0 wins first.
    rst = 1'b1;
    m0_req = 1; m0_addr = 14'h0010;
    m1_req = 1; m1_addr = 14'h0020;
    mid(); check("t1_c0_m0_gnt", 32'(m0_gnt), 1); check("t1_c0_m1_gnt", 32'(m1_gnt), 0);
    tick(); m0_req = 0;
    mid(); check("t1_c1_m1_gnt", 32'(m1_gnt), 1); check("t1_c1_m0_rdata", m0_rdata, 32'hC0DE0010);
    tick(); m1_req = 0;
    mid(); check("t1_c2_m1_rdata", m1_rdata, 32'hC0DE0020); check("t1_c2_m0_rdata", m0_rdata, 0);
    tick();

    // Partial write at the top address, then read it back.
    m0_req = 1; m0_we = 1; m0_addr = 14'h3FFF; m0_wdata = 32'hA5A5A5A5; m0_be = 4'b0011;
    mid(); check("t2_wr_en", 32'(ram_wr_en), 1); check("t2_wr_be", 32'(ram_wr_byte_en), 3);
    tick(); m0_we = 0; m0_be = 4'b0000;
    mid(); check("t2_rd_gnt", 32'(m0_gnt), 1);
    tick(); m0_req = 0;
    mid(); check("t2_rdata", m0_rdata, 32'hC0DEA5A5);
    tick();

    // Write with no byte enables: granted, memory unchanged.
    m0_req = 1; m0_we = 1; m0_addr = 14'h0010; m0_wdata = 32'hFFFFFFFF; m0_be = 4'b0000;
    mid(); check("t2b_gnt", 32'(m0_gnt), 1);
    tick(); m0_we = 0;
    mid(); check("t2b_no_rvalid", 32'(m0_rvalid), 0);
    tick(); m0_req = 0;
    mid(); check("t2b_rdata", m0_rdata, 32'hC0DE0010);
    tick();

    // Lone port-1 read leaves port 1 as most recent.
    m1_req = 1; m1_addr = 14'h0030;
    tick(); m1_req = 0;
    tick();

    // Continuous contention for 8 cycles.
    c0 = 0; c1 = 0; dual = 0;
    for (int k = 0; k < 8; k++) begin
      m0_req = 1; m0_addr = AW'(14'h0100 + k);
      m1_req = 1; m1_addr = AW'(14'h0200 + k);
      mid();
      check("t3_alternate", 32'(m0_gnt), 32'(k % 2 == 0));
      c0 += int'(m0_gnt); c1 += int'(m1_gnt);
      if (m0_gnt && m1_gnt) dual++;
      tick();
    end
    m0_req = 0; m1_req = 0;
    check("t3_m0_count", 32'(c0), 4);
    check("t3_m1_count", 32'(c1), 4);
    check("t3_dual", 32'(dual), 0);
    tick();

    // Lone port-0 read so port 1 wins the locking conflict.
    m0_req = 1; m0_addr = 14'h0040;
    tick(); m0_req = 0;
    tick();

    // Bounded lock with both ports requesting.
    m0_req = 1; m0_addr = 14'h0050;
    m1_req = 1; m1_addr = 14'h0060; m1_lock = 1;
    for (int k = 0; k < 10; k++) begin
      exp1 = (k < LM) ? 1'b1 : (k % 2 == 1);
      mid(); check("t4_lock_seq", 32'(m1_gnt), 32'(exp1));
      tick();
    end
    m1_lock = 0;
    mid(); check("t4_unlock_m0", 32'(m0_gnt), 1);
    tick(); m1_lock = 1;
    mid(); check("t4_relock_m1", 32'(m1_gnt), 1);
    tick();
    mid(); check("t4_locked_m0_blocked", 32'(m0_gnt), 0);
    tick(); m1_lock = 0;
    mid(); check("t4_release_same_cycle", 32'(m0_gnt), 1);
    tick();
    m0_req = 0; m1_req = 0;
    tick();

    // Reset while locked with a read in flight.
    m1_req = 1; m1_lock = 1; m1_addr = 14'h0070;
    tick(); m1_addr = 14'h0071;
    mid(); check("t5_pre_rvalid", 32'(m1_rvalid), 1);
    tick(); rst = 1'b0; m1_req = 0;
    mid(); check("t5_rvalid_dropped", 32'(m1_rvalid), 0); check("t5_rdata_zero", m1_rdata, 0);
    tick();
    m0_req = 1; m0_addr = 14'h0080; m1_req = 1; m1_addr = 14'h0090;
    mid(); check("t5_no_gnt_in_reset", 32'(m0_gnt | m1_gnt), 0);
    tick(); rst = 1'b1;
    mid(); check("t5_first_m0", 32'(m0_gnt), 1); check("t5_no_spurious", 32'(m1_rvalid), 0);
    tick(); m0_req = 0;
    mid(); check("t5_then_m1", 32'(m1_gnt), 1); check("t5_m0_rdata", m0_rdata, 32'hC0DE0080);
    tick(); m1_req = 0; m1_lock = 0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dram_arbiter.md
# dram_arbiter

Two-port arbiter that shares the single-port 16K x 32 data RAM (14-bit word address, 4 byte enables, 1-cycle read latency, no output register) between the CPU load/store unit (port 0) and the debug/loader master (port 1). It muxes one access per cycle onto the RAM and resolves conflicts round-robin. It also supports a bounded lock so the loader can run uninterrupted bursts, and it returns read data to the master that issued the read. It sits directly in front of the data RAM instance; both masters connect only through it.

## Interface
- ADDR_WIDTH, 14, RAM word-address width
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- LOCK_MAX, 64, maximum consecutive cycles port 1 may hold the lock (2..1023)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- m0_req, m1_req  in  1  access request
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  ADDR_WIDTH  word address
- m0_wdata, m1_wdata  in  DATA_WIDTH  write data
- m0_be, m1_be  in  DATA_WIDTH/8  write byte enables
- m1_lock  in  1  port 1 requests exclusive ownership
- m0_gnt, m1_gnt  out  1  combinational accept; the access completes this cycle
- m0_rvalid, m1_rvalid  out  1  read data valid, registered
- m0_rdata, m1_rdata  out  DATA_WIDTH  read data; 0 when the matching rvalid is 0
- ram_addr  out  ADDR_WIDTH  to RAM addr
- ram_wr_data  out  DATA_WIDTH  to RAM wr_data
- ram_wr_en  out  1  to RAM wr_en
- ram_wr_byte_en  out  DATA_WIDTH/8  to RAM wr_byte_en
- ram_rd_data  in  DATA_WIDTH  from RAM rd_data

## Operation
- Grant is combinational, in the same cycle as req. There is at most one grant per cycle. The granted master's address, data and enables are muxed onto ram_*.
- With no grant: ram_wr_en=0, ram_wr_byte_en=0, ram_addr holds port 0's address.
- Only one port requesting: that port is granted, unless locked out (see lock).
- Both ports requesting: the port that was not granted most recently wins. The last_gnt register updates on every grant.
- ram_wr_en = granted & we. A write with be=0 is still granted, changes no memory and produces no rvalid.
- A granted read sets mX_rvalid=1 on the next cycle. mX_rdata = ram_rd_data while mX_rvalid=1.
- Back-to-back reads are fully pipelined: one per cycle and per port, across ports in any interleave.
- Lock FSM states:
  - IDLE -> LOCKED when m1 is granted with m1_lock=1. lock_cnt is loaded with 1.
  - LOCKED: m0_gnt is forced to 0, and m1 is granted whenever m1_req=1. lock_cnt increments every cycle.
  - LOCKED -> IDLE when m1_lock=0.
  - LOCKED -> BLOCKED when lock_cnt reaches LOCK_MAX. This is a forced release, and last_gnt is set to 1 so port 0 wins the next conflict.
  - BLOCKED: arbitration is normal round-robin and m1_lock is ignored.
  - BLOCKED -> IDLE when m1_lock=0.
- lock_cnt is ceil(log2(LOCK_MAX+1)) bits and saturates; it never wraps.

## Timing
- Reset values (rst=0, asynchronous): m0_rvalid=m1_rvalid=0, m0_rdata=m1_rdata=0, last_gnt=1 (port 0 wins the first conflict), lock state IDLE, lock_cnt=0. Combinational outputs follow the reset-state registers.
- Read latency from grant cycle to rvalid/rdata is 1 cycle. Write latency is 0: the write occurs at the grant edge.
- Read-after-write to the same address on the next cycle returns the new data. This follows the RAM's NORMAL_WRITE mode.
- Same-cycle write by one port and read by the other is impossible, since only one port is granted.
- The requester must hold req and its payload until it sees gnt. The arbiter stores no requests.
- When reset is asserted mid-burst, pending rvalids are dropped and the lock is cleared. No spurious rvalid appears after rst is released.
- If rst deasserts while req is high, the grant is given on the first cycle after release.
- Lock release (m1_lock low) takes effect in the same cycle: port 0 may be granted in that cycle.

## Test plan
- After reset, both ports request reads of addr 0x0010 / 0x0020 together → m0 granted cycle 0 and m1 cycle 1. m0_rvalid is seen at cycle 1 and m1_rvalid at cycle 2, with correct data; m0_rdata=0 at cycle 2.
- Port 0 writes 0xA5A5A5A5 with be=4'b0011 to 0x3FFF (top address), then reads it next cycle → rdata = original[31:16] concatenated with 0xA5A5.
- Both ports request continuously for 8 cycles → grants alternate m0,m1,m0,...; each port gets exactly 4 grants and there is never a dual grant.
- LOCK_MAX=4, m1_lock=1 with both ports requesting continuously → m1 is granted 4 consecutive cycles, then m0 is granted. Arbitration then alternates until m1_lock drops, and relocking succeeds after m1_lock is pulsed low.
- Reset asserted in the cycle after a granted read → no rvalid after rst rises, lock IDLE, and the next conflict goes to port 0.
